// File: rtl/divider_pkg.sv
`default_nettype none
// ==================================================================
// divider_pkg : shared FSM state type and default operand width
// Rev 1.0
// ==================================================================
package divider_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ==================================================================
// div_step : one restoring-division iteration (compare, subtract, q bit)
// Rev 1.0
// ==================================================================
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;

    assign w_trial = {rem_i, bit_i};
    assign q_o     = (w_trial >= {1'b0, divisor_i});
    // rem_i < divisor_i always holds, so a successful subtract fits in WIDTH bits
    assign w_diff  = w_trial[WIDTH-1:0] - divisor_i;
    assign rem_o   = q_o ? w_diff : w_trial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/restoring_divider_8.sv
`default_nettype none
// ==================================================================
// restoring_divider_8 : sequential restoring divider, 2W / W -> W, W cycles
// Rev 1.0
// ==================================================================
module restoring_divider_8
    import divider_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow
);

    localparam int                c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               overflow_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   dvd_lo_q;
    logic [c_CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_lo_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (w_rem_next),
        .q_o       (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            dvd_lo_q    <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvsr_q     <= divisor;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        // A high half >= divisor means the quotient cannot fit in WIDTH bits
                        if ((divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor)) begin
                            quo_q       <= '1;
                            rem_q       <= '0;
                            overflow_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            quo_q      <= '0;
                            rem_q      <= dividend[2*WIDTH-1:WIDTH];
                            dvd_lo_q   <= dividend[WIDTH-1:0];
                            overflow_q <= 1'b0;
                            state_q    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q    <= w_rem_next;
                    quo_q    <= {quo_q[WIDTH-2:0], w_q_bit};
                    dvd_lo_q <= {dvd_lo_q[WIDTH-2:0], 1'b0};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_8.sv
`default_nettype none
// ==================================================================
// tb_restoring_divider_8 : directed and random checks of restoring_divider_8
// Rev 1.0
// ==================================================================
module tb_restoring_divider_8;

    localparam int c_W       = 8;
    localparam int c_TIMEOUT = 50;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*c_W-1:0] dividend;
    logic [c_W-1:0] divisor;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           overflow;

    int n_tests = 0;
    int n_fail  = 0;

    restoring_divider_8 #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents operands until accepted; returns 1ns after the accepting edge.
    task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
        int n = 0;
        while (!in_ready && n < c_TIMEOUT) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'hBE;
    endtask

    // Waits for out_valid; reports edges after the accepting edge and in_ready seen meanwhile.
    task automatic wait_valid(output int lat, output int rdy_seen);
        lat = 0;
        rdy_seen = 0;
        while (!out_valid && lat < c_TIMEOUT) begin
            if (in_ready) rdy_seen++;
            @(posedge clk); #1; lat++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_after_hs"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_iready_after_hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er, input logic eo);
        int lat;
        int rdy;
        start_op(dvd, dvs);
        wait_valid(lat, rdy);
        check({tag, "_latency"}, lat, eo ? 32'd0 : 32'(c_W));
        check({tag, "_busy_in_ready"}, rdy, 32'd0);
        check({tag, "_result"}, {15'd0, overflow, quotient, remainder}, {15'd0, eo, eq, er});
        handshake(tag);
    endtask

    initial begin
        int lat;
        int rdy;
        int seen;
        logic [15:0] rd;
        logic [7:0]  rv;
        logic [7:0]  eq;
        logic [7:0]  er;
        logic        eo;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient",  {24'd0, quotient},  32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("nominal",   16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0);
        run_op("div_zero",  16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1);
        run_op("q_ovf",     16'hFF00, 8'h0F, 8'hFF, 8'h00, 1'b1);
        run_op("max_q",     16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("hi_eq_dvs", 16'h0A00, 8'h0A, 8'hFF, 8'h00, 1'b1);
        run_op("hi_lt_dvs", 16'h09FF, 8'h0A, 8'hFF, 8'h09, 1'b0);
        run_op("div_one",   16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0);
        run_op("zero_dvd",  16'h0000, 8'h05, 8'h00, 8'h00, 1'b0);

        // Backpressure: hold the result while out_ready is low and new operands are offered
        start_op(16'h3039, 8'h7B);
        wait_valid(lat, rdy);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'h0100;
            divisor  = 8'h02;
            check("bp_result", {15'd0, overflow, quotient, remainder}, {15'd0, 1'b0, 8'h64, 8'h2D});
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        handshake("bp");
        @(posedge clk); #1;
        check("bp_idle_hold", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset at BUSY iteration 4 abandons the operation
        start_op(16'h3039, 8'h7B);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_result", {15'd0, overflow, quotient, remainder}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_result", seen, 32'd0);
        run_op("after_rst", 16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0);

        // Random operand pairs against a reference quotient and the division identity
        for (int i = 0; i < 10000; i++) begin
            rd = 16'($urandom);
            rv = 8'($urandom);
            if (i % 4 == 0) rd[15:8] = rd[15:8] % ((rv == 8'd0) ? 8'd1 : rv);
            if (rv == 8'd0 || rd[15:8] >= rv) begin
                eq = 8'hFF; er = 8'h00; eo = 1'b1;
            end else begin
                eq = 8'(rd / {8'd0, rv});
                er = 8'(rd % {8'd0, rv});
                eo = 1'b0;
            end
            start_op(rd, rv);
            wait_valid(lat, rdy);
            check("rnd_result", {15'd0, overflow, quotient, remainder}, {15'd0, eo, eq, er});
            if (!eo) begin
                check("rnd_identity", 32'(quotient) * 32'(rv) + 32'(remainder), 32'(rd));
                check("rnd_rem_lt_dvs", {31'd0, remainder < rv}, 32'd1);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
